tx_byte_framer: RTL and testbench
=================================

TX_BYTE_FRAMER -- requirements
Module: tx_byte_framer

Interface
REQ-001 SHALL have parameter A1_BYTE, default 8'hF6, framing byte A1.
REQ-002 SHALL have parameter A2_BYTE, default 8'h28, framing byte A2.
REQ-003 SHALL have parameter FRM_BYTES, default 14'd9720, bytes per STM-4 frame (9 rows x 270 cols x 4).
REQ-004 SHALL have port sdh_clk  in  1  transmit byte clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_payload_i  in  8  payload byte, sampled on edges where tx_payload_req=1.
REQ-007 SHALL have port tx_oh_i  in  8  overhead byte, sampled on edges where tx_oh_req=1.
REQ-008 SHALL have port tx_j0_i  in  8  J0 trace byte, sampled at its slot.
REQ-009 SHALL have port tx_a1_err_inj  in  1  corrupt A1 bytes of the next frame started.
REQ-010 SHALL have port tx_b1_err_inj  in  1  corrupt B1 of the next frame started.
REQ-011 SHALL have port tx_data_o  out  8  framed, scrambled byte stream.
REQ-012 SHALL have port tx_payload_req  out  1  payload byte requested this cycle.
REQ-013 SHALL have port tx_oh_req  out  1  overhead byte requested this cycle.
REQ-014 SHALL have port tx_frm_start_o  out  1  pulse coincident with first A1 on tx_data_o.

Function
REQ-015 SHALL keep counters mu (0..3, fastest), col (0..269), row (0..8); byte index = row*1080 + col*4 + mu; full wrap after row 8, col 269, mu 3.
REQ-016 SHALL classify slots: col<=8 overhead, col>=9 payload (9396 payload slots/frame).
REQ-017 SHALL map row 0: cols 0..2 A1 (12 bytes), cols 3..5 A2 (12 bytes), col 6 mu 0 J0.
REQ-018 SHALL place B1 at row 1 col 0 mu 0.
REQ-019 SHALL source every other overhead slot from tx_oh_i (298 tx_oh_req per frame).
REQ-020 SHALL drive tx_payload_req/tx_oh_req combinationally from the current counters; upstream supplies data in the same cycle.
REQ-021 SHALL register tx_data_o one cycle after the slot's counter cycle (latency 1); tx_frm_start_o SHALL be registered identically.
REQ-022 SHALL scramble with frame-synchronous 1+x^6+x^7, 8 bits/byte, MSB first; state SHALL preset to 7'h7F at byte index 36; row 0 overhead (indices 0..35) SHALL be unscrambled; state SHALL advance only on scrambled bytes.
REQ-023 SHALL compute BIP-8 as XOR of all tx_data_o bytes of a frame (post-scrambling); value SHALL latch at frame wrap and insert pre-scrambling at B1 of the following frame.
REQ-024 SHALL transmit B1=8'h00 in the first frame after reset.
REQ-025 SHALL capture tx_a1_err_inj/tx_b1_err_inj (sticky) and apply them to the next frame starting at index 0; A1 bytes SHALL then be 8'h00; B1 SHALL be XORed with 8'h01; flags SHALL clear at that frame's end.
REQ-026 SHALL start the frame when injection asserts on the same cycle as index 0; injection SHALL apply to that frame.

Reset
REQ-027 SHALL reset tx_data_o=8'h00, tx_frm_start_o=0, counters=0, BIP accumulator and latched B1=0, injection flags=0, scrambler=7'h7F.
REQ-028 SHALL hold tx_payload_req=tx_oh_req=0 while rst_n=0; first cycle after release SHALL be index 0 (A1).
REQ-029 SHALL, on reset assertion mid-frame, abandon the frame immediately; restart SHALL begin at A1 with B1=8'h00.

Verification
REQ-030 SHALL verify: reset release, tx_j0_i=8'h01 -> tx_data_o 12xF6, 12x28, then 01 at index 24; tx_frm_start_o every 9720 cycles.
REQ-031 SHALL verify: tx_payload_i=tx_oh_i=0 -> per frame 9396 payload_req, 298 oh_req; bytes at indices 36,37,38 = FE,04,18.
REQ-032 SHALL verify: random payload over 3 frames -> B1 of frames 2,3 equals XOR of prior frame's tx_data_o bytes; frame 1 B1=00.
REQ-033 SHALL verify: tx_b1_err_inj pulse mid-frame 2 -> frame 3 B1 = reference XOR 8'h01; frame 4 correct.
REQ-034 SHALL verify: tx_a1_err_inj each frame for 5 frames, looped into rx_byte_framer -> rx_stm_oof asserts; injection removed 2 frames -> OOF clears.
REQ-035 SHALL verify: rst_n pulse at index 5000 -> tx_data_o=00 during reset; next output frame starts F6 with B1=00.

Source files
------------

// File: rtl/tx_byte_framer.sv
// STM-4 transmit byte framer: inserts A1/A2/J0/B1, muxes overhead and payload,
// scrambles with the frame-synchronous x^7+x^6+1 sequence and computes BIP-8.
module tx_byte_framer #(
    parameter logic [7:0]  A1_BYTE   = 8'hF6,
    parameter logic [7:0]  A2_BYTE   = 8'h28,
    parameter logic [13:0] FRM_BYTES = 14'd9720
) (
    input  logic       sdh_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_payload_i,
    input  logic [7:0] tx_oh_i,
    input  logic [7:0] tx_j0_i,
    input  logic       tx_a1_err_inj,
    input  logic       tx_b1_err_inj,
    output logic [7:0] tx_data_o,
    output logic       tx_payload_req,
    output logic       tx_oh_req,
    output logic       tx_frm_start_o
);
    localparam logic [3:0] LAST_ROW = 4'(FRM_BYTES / 14'd1080 - 14'd1);

    logic [1:0] r_mu;
    logic [8:0] r_col;
    logic [3:0] r_row;
    logic [6:0] r_scr;
    logic [7:0] r_bip;
    logic [7:0] r_b1;
    logic [7:0] r_data;
    logic       r_frm_start;
    logic       r_a1_pend, r_a1_act;
    logic       r_b1_pend, r_b1_act;

    logic       w_wrap, w_idx0, w_oh_slot, w_pay_slot;
    logic       w_a1, w_a2, w_j0, w_b1, w_scr_en, w_scr_seed;
    logic       w_a1_inj, w_b1_inj;
    logic [6:0] w_scr_in;
    logic [7:0] w_raw, w_tx;
    logic [14:0] w_scr_res;

    // Returns {next_state, scrambled_byte}; MSB of the byte meets the sequence first.
    function automatic logic [14:0] scramble(input logic [6:0] st, input logic [7:0] d);
        logic [6:0] s;
        logic [7:0] o;
        s = st;
        o = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            o[i] = d[i] ^ s[6];
            s    = {s[5:0], s[6] ^ s[5]};
        end
        return {s, o};
    endfunction

    assign w_wrap     = (r_row == LAST_ROW) && (r_col == 9'd269) && (r_mu == 2'd3);
    assign w_idx0     = (r_row == 4'd0) && (r_col == 9'd0) && (r_mu == 2'd0);
    assign w_oh_slot  = (r_col <= 9'd8);
    assign w_pay_slot = !w_oh_slot;
    assign w_a1       = (r_row == 4'd0) && (r_col <= 9'd2);
    assign w_a2       = (r_row == 4'd0) && (r_col >= 9'd3) && (r_col <= 9'd5);
    assign w_j0       = (r_row == 4'd0) && (r_col == 9'd6) && (r_mu == 2'd0);
    assign w_b1       = (r_row == 4'd1) && (r_col == 9'd0) && (r_mu == 2'd0);
    assign w_scr_en   = !((r_row == 4'd0) && w_oh_slot);
    assign w_scr_seed = (r_row == 4'd0) && (r_col == 9'd9) && (r_mu == 2'd0);

    assign tx_payload_req = rst_n & w_pay_slot;
    assign tx_oh_req      = rst_n & w_oh_slot & !(w_a1 | w_a2 | w_j0 | w_b1);

    // A request arriving on the index-0 cycle already belongs to the frame being started.
    assign w_a1_inj = w_idx0 ? (r_a1_pend | tx_a1_err_inj) : r_a1_act;
    assign w_b1_inj = w_idx0 ? (r_b1_pend | tx_b1_err_inj) : r_b1_act;

    always_comb begin
        w_raw = tx_payload_i;
        if (w_a1)
            w_raw = w_a1_inj ? 8'h00 : A1_BYTE;
        else if (w_a2)
            w_raw = A2_BYTE;
        else if (w_j0)
            w_raw = tx_j0_i;
        else if (w_b1)
            w_raw = r_b1 ^ {7'd0, w_b1_inj};
        else if (w_oh_slot)
            w_raw = tx_oh_i;
    end

    assign w_scr_in  = w_scr_seed ? 7'h7F : r_scr;
    assign w_scr_res = scramble(w_scr_in, w_raw);
    assign w_tx      = w_scr_en ? w_scr_res[7:0] : w_raw;

    always_ff @(posedge sdh_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mu        <= 2'd0;
            r_col       <= 9'd0;
            r_row       <= 4'd0;
            r_scr       <= 7'h7F;
            r_bip       <= 8'h00;
            r_b1        <= 8'h00;
            r_data      <= 8'h00;
            r_frm_start <= 1'b0;
            r_a1_pend   <= 1'b0;
            r_a1_act    <= 1'b0;
            r_b1_pend   <= 1'b0;
            r_b1_act    <= 1'b0;
        end else begin
            r_mu <= r_mu + 2'd1;
            if (r_mu == 2'd3) begin
                if (r_col == 9'd269) begin
                    r_col <= 9'd0;
                    r_row <= (r_row == LAST_ROW) ? 4'd0 : r_row + 4'd1;
                end else begin
                    r_col <= r_col + 9'd1;
                end
            end

            r_data      <= w_tx;
            r_frm_start <= w_idx0;
            if (w_scr_en)
                r_scr <= w_scr_res[14:8];

            // BIP covers the bytes as transmitted, including the last one of the frame.
            if (w_wrap) begin
                r_b1  <= r_bip ^ w_tx;
                r_bip <= 8'h00;
            end else begin
                r_bip <= r_bip ^ w_tx;
            end

            if (w_idx0) begin
                r_a1_act  <= r_a1_pend | tx_a1_err_inj;
                r_b1_act  <= r_b1_pend | tx_b1_err_inj;
                r_a1_pend <= 1'b0;
                r_b1_pend <= 1'b0;
            end else begin
                if (tx_a1_err_inj) r_a1_pend <= 1'b1;
                if (tx_b1_err_inj) r_b1_pend <= 1'b1;
                if (w_wrap) begin
                    r_a1_act <= 1'b0;
                    r_b1_act <= 1'b0;
                end
            end
        end
    end

    assign tx_data_o      = r_data;
    assign tx_frm_start_o = r_frm_start;
endmodule

// File: tb/tb_tx_byte_framer.sv
// Directed bench for tx_byte_framer: framing bytes, scrambler, request pattern,
// BIP-8 chaining, error injection and mid-frame reset.
module tb_tx_byte_framer;
    logic       sdh_clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_payload_i, tx_oh_i, tx_j0_i;
    logic       tx_a1_err_inj, tx_b1_err_inj;
    logic [7:0] tx_data_o;
    logic       tx_payload_req, tx_oh_req, tx_frm_start_o;

    tx_byte_framer dut (
        .sdh_clk(sdh_clk), .rst_n(rst_n),
        .tx_payload_i(tx_payload_i), .tx_oh_i(tx_oh_i), .tx_j0_i(tx_j0_i),
        .tx_a1_err_inj(tx_a1_err_inj), .tx_b1_err_inj(tx_b1_err_inj),
        .tx_data_o(tx_data_o), .tx_payload_req(tx_payload_req),
        .tx_oh_req(tx_oh_req), .tx_frm_start_o(tx_frm_start_o)
    );

    always #5 sdh_clk = ~sdh_clk;

    int         nvec = 0;
    int         nerr = 0;
    int         cur  = 0;
    int         obs_idx = 0;
    logic [7:0] obs;
    logic [7:0] fx = 8'h00;
    logic [7:0] b1_ref = 8'h00;
    logic       a1_zero = 1'b0;
    logic       b1_flip = 1'b0;
    logic       rnd = 1'b0;
    int         npay = 0;
    int         noh = 0;
    logic [7:0] ks [0:9719];

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s idx=%0d observed=%02h expected=%02h", tag, obs_idx, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s idx=%0d observed=%b expected=%b", tag, cur, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input int got, input int exp);
        nvec++;
        assert (got == exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One byte slot: check requests for slot cur, clock it, check the emitted byte.
    task automatic tick();
        int r, c, m;
        logic pay, ovh;
        logic [7:0] dp, doh, dj, exp;
        if (rnd) begin
            tx_payload_i = 8'($urandom);
            tx_oh_i      = 8'($urandom);
        end
        r = cur / 1080;
        c = (cur % 1080) / 4;
        m = cur % 4;
        pay = (c >= 9);
        ovh = (c <= 8) && !(r == 0 && c <= 5) && !(r == 0 && c == 6 && m == 0)
              && !(r == 1 && c == 0 && m == 0);
        chk1("payload_req", tx_payload_req, pay);
        chk1("oh_req", tx_oh_req, ovh);
        if (cur == 0) begin
            npay = 0;
            noh  = 0;
        end
        npay += int'(tx_payload_req);
        noh  += int'(tx_oh_req);
        dp  = tx_payload_i;
        doh = tx_oh_i;
        dj  = tx_j0_i;
        @(posedge sdh_clk);
        #1;
        obs     = tx_data_o;
        obs_idx = cur;
        if (r == 0 && c <= 2)                  exp = a1_zero ? 8'h00 : 8'hF6;
        else if (r == 0 && c <= 5)             exp = 8'h28;
        else if (r == 0 && c == 6 && m == 0)   exp = dj;
        else if (r == 1 && c == 0 && m == 0)   exp = b1_ref ^ {7'd0, b1_flip} ^ ks[cur];
        else if (pay)                          exp = dp ^ ks[cur];
        else                                   exp = doh ^ ks[cur];
        chk8("data", obs, exp);
        chk1("frm_start", tx_frm_start_o, (cur == 0));
        fx = (cur == 0) ? obs : (fx ^ obs);
        if (cur == 9719) begin
            b1_ref = fx;
            chkn("payload_req_count", npay, 9396);
            chkn("oh_req_count", noh, 298);
            cur = 0;
        end else begin
            cur = cur + 1;
        end
    endtask

    task automatic run_to(input int t);
        int n = 0;
        while (cur != t && n < 20000) begin
            tick();
            n++;
        end
        chkn("run_to_reached", cur, t);
    endtask

    task automatic chk_reset_outputs();
        chk8("rst_data", tx_data_o, 8'h00);
        chk1("rst_frm_start", tx_frm_start_o, 1'b0);
        chk1("rst_payload_req", tx_payload_req, 1'b0);
        chk1("rst_oh_req", tx_oh_req, 1'b0);
    endtask

    initial begin
        logic [6:0] s;
        logic [7:0] b;
        // Frame-synchronous keystream by index, zero over the unscrambled row-0 overhead.
        s = 7'h7F;
        for (int i = 0; i < 9720; i++) begin
            if (i < 36) begin
                ks[i] = 8'h00;
            end else begin
                b = 8'h00;
                for (int k = 7; k >= 0; k--) begin
                    b[k] = s[6];
                    s    = {s[5:0], s[6] ^ s[5]};
                end
                ks[i] = b;
            end
        end

        rst_n = 1'b0;
        tx_payload_i = 8'h00;
        tx_oh_i = 8'h00;
        tx_j0_i = 8'h01;
        tx_a1_err_inj = 1'b0;
        tx_b1_err_inj = 1'b0;
        repeat (3) @(posedge sdh_clk);
        #1;
        chk_reset_outputs();

        @(negedge sdh_clk);
        rst_n = 1'b1;
        #1;
        tick();
        chk8("first_a1", obs, 8'hF6);

        // Frame 1: zero inputs, J0 and first scrambled bytes against hand values
        run_to(25);
        chk8("j0_byte", obs, 8'h01);
        run_to(37);
        chk8("scr_36", obs, 8'hFE);
        tick();
        chk8("scr_37", obs, 8'h04);
        tick();
        chk8("scr_38", obs, 8'h18);
        run_to(1081);
        chk8("b1_first_frame", obs, ks[1080]);
        run_to(0);

        // Frame 2: random traffic, B1 error request mid-frame
        rnd = 1'b1;
        run_to(4000);
        tx_b1_err_inj = 1'b1;
        tick();
        tx_b1_err_inj = 1'b0;
        run_to(0);

        // Frame 3: corrupted B1; frame 4 back to the true parity
        b1_flip = 1'b1;
        run_to(1081);
        b1_flip = 1'b0;
        run_to(0);
        run_to(0);

        // Frame 5: A1 error request on the index-0 cycle itself
        tx_a1_err_inj = 1'b1;
        a1_zero = 1'b1;
        tick();
        tx_a1_err_inj = 1'b0;
        run_to(12);
        a1_zero = 1'b0;
        run_to(0);

        // Frame 6: restored A1, BIP includes frame 5's zeroed A1 bytes, then reset mid-frame
        run_to(5000);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) begin
            @(posedge sdh_clk);
            #1;
            chk_reset_outputs();
        end
        @(negedge sdh_clk);
        rst_n = 1'b1;
        cur = 0;
        fx = 8'h00;
        b1_ref = 8'h00;
        #1;
        tick();
        chk8("restart_a1", obs, 8'hF6);
        run_to(1081);
        chk8("b1_after_reset", obs, ks[1080]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
